// File: rtl/control_unit.sv
// Hardwired control sequencer: walks fetch (T0-T2) and a per-class execute
// sequence (T3-T7), decoding IR[31:27] into datapath strobes and memory handshakes.
module control_unit #(
  parameter logic [4:0] ALU_ADD = 5'b00000
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        MemReady,
  output logic        PCout,
  output logic        Zlowout,
  output logic        ZHighout,
  output logic        MDRout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        HIin,
  output logic        LOin,
  output logic        Rin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic [4:0]  ALUop,
  output logic        Read,
  output logic        Write,
  output logic        Run,
  output logic        Illegal
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [4:0] opcode;
  logic       is_rtype, is_addi, is_ld, is_st, is_mul, is_div, is_nop, is_halt;
  logic       is_mem, is_muldiv, is_alu;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  assign is_rtype  = (opcode <= 5'b01000);
  assign is_addi   = (opcode == 5'b01001);
  assign is_ld     = (opcode == 5'b01010);
  assign is_st     = (opcode == 5'b01011);
  assign is_mul    = (opcode == 5'b01111);
  assign is_div    = (opcode == 5'b10000);
  assign is_nop    = (opcode == 5'b10101);
  assign is_halt   = (opcode == 5'b11011);
  assign is_mem    = is_ld | is_st;
  assign is_muldiv = is_mul | is_div;
  assign is_alu    = is_rtype | is_addi;

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    ZHighout = 1'b0;
    MDRout   = 1'b0;
    Cout     = 1'b0;
    BAout    = 1'b0;
    Rout     = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    ZLowIn   = 1'b0;
    ZHighIn  = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Rin      = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    ALUop    = 5'b00000;
    Read     = 1'b0;
    Write    = 1'b0;
    Illegal  = 1'b0;
    Run      = (state_q != S_RESET) && (state_q != S_HALT);

    unique case (state_q)
      S_RESET: state_d = S_T0;
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        PCin    = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (MemReady) state_d = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        // Undefined opcodes still visit T3 so Illegal gets its single-cycle pulse.
        if (is_nop)       state_d = S_T0;
        else if (is_halt) state_d = S_HALT;
        else              state_d = S_T3;
      end
      S_T3: begin
        state_d = S_T4;
        if (is_alu) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else if (is_mem) begin
          Grb   = 1'b1;
          BAout = 1'b1;
          Yin   = 1'b1;
        end else if (is_muldiv) begin
          Gra  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else begin
          Illegal = 1'b1;
          state_d = S_T0;
        end
      end
      S_T4: begin
        state_d = S_T5;
        ZLowIn  = 1'b1;
        if (is_rtype) begin
          Grc   = 1'b1;
          Rout  = 1'b1;
          ALUop = opcode;
        end else if (is_muldiv) begin
          Grb     = 1'b1;
          Rout    = 1'b1;
          ZHighIn = 1'b1;
          ALUop   = opcode;
        end else begin
          Cout  = 1'b1;
          ALUop = ALU_ADD;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_alu) begin
          Gra     = 1'b1;
          Rin     = 1'b1;
          state_d = S_T0;
        end else if (is_mem) begin
          MARin   = 1'b1;
          state_d = S_T6;
        end else begin
          LOin    = 1'b1;
          state_d = S_T6;
        end
      end
      S_T6: begin
        if (is_ld) begin
          Read  = 1'b1;
          MDRin = 1'b1;
          if (MemReady) state_d = S_T7;
        end else if (is_st) begin
          Gra     = 1'b1;
          Rout    = 1'b1;
          MDRin   = 1'b1;
          state_d = S_T7;
        end else begin
          ZHighout = 1'b1;
          HIin     = 1'b1;
          state_d  = S_T0;
        end
      end
      S_T7: begin
        if (is_st) begin
          Write = 1'b1;
          if (MemReady) state_d = S_T0;
        end else begin
          MDRout  = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
          state_d = S_T0;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: each instruction is expanded from the
// per-class strobe table into an expected per-cycle control-word sequence.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Clear;
  logic [31:0] IR;
  logic        MemReady;
  logic PCout, Zlowout, ZHighout, MDRout, Cout, BAout, Rout;
  logic PCin, IncPC, MARin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin;
  logic Gra, Grb, Grc;
  logic [4:0] ALUop;
  logic Read, Write, Run, Illegal;

  control_unit #(.ALU_ADD(5'b00000)) dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .MemReady(MemReady),
    .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .Cout(Cout), .BAout(BAout), .Rout(Rout),
    .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin), .Rin(Rin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .ALUop(ALUop),
    .Read(Read), .Write(Write), .Run(Run), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  logic [29:0] obs;
  assign obs = {PCout, Zlowout, ZHighout, MDRout, Cout, BAout, Rout,
                PCin, IncPC, MARin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin,
                Gra, Grb, Grc, ALUop, Read, Write, Run, Illegal};

  localparam logic [29:0] PCOUT = 30'd1 << 29, ZLOWOUT = 30'd1 << 28, ZHIGHOUT = 30'd1 << 27;
  localparam logic [29:0] MDROUT = 30'd1 << 26, COUT = 30'd1 << 25, BAOUT = 30'd1 << 24;
  localparam logic [29:0] ROUT = 30'd1 << 23, PCIN = 30'd1 << 22, INCPC = 30'd1 << 21;
  localparam logic [29:0] MARIN = 30'd1 << 20, MDRIN = 30'd1 << 19, IRIN = 30'd1 << 18;
  localparam logic [29:0] YIN = 30'd1 << 17, ZLOWIN = 30'd1 << 16, ZHIGHIN = 30'd1 << 15;
  localparam logic [29:0] HIIN = 30'd1 << 14, LOIN = 30'd1 << 13, RIN = 30'd1 << 12;
  localparam logic [29:0] GRA = 30'd1 << 11, GRB = 30'd1 << 10, GRC = 30'd1 << 9;
  localparam logic [29:0] READ = 30'd1 << 3, WRITE = 30'd1 << 2, RUN = 30'd1 << 1, ILLEGAL = 30'd1;

  typedef struct {
    logic [29:0] ctl;
    bit          wait_mem;
  } step_t;

  step_t steps[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [29:0] alu(input logic [4:0] op);
    return 30'(op) << 4;
  endfunction

  function automatic bit op_legal(input logic [4:0] op);
    return (op <= 5'd11) || (op == 5'd15) || (op == 5'd16) || (op == 5'd21) || (op == 5'd27);
  endfunction

  task automatic check(input string tag, input logic [29:0] got, input logic [29:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic add_step(input logic [29:0] c, input bit w);
    step_t s;
    s.ctl = c | RUN;
    s.wait_mem = w;
    steps.push_back(s);
  endtask

  // Expected sequence for one instruction, straight from the class table.
  task automatic build_steps(input logic [4:0] op);
    steps.delete();
    add_step(PCOUT | MARIN | INCPC | PCIN, 1'b0);
    add_step(READ | MDRIN, 1'b1);
    add_step(MDROUT | IRIN, 1'b0);
    if (op <= 5'd9) begin
      add_step(GRB | ROUT | YIN, 1'b0);
      if (op == 5'd9) add_step(COUT | ZLOWIN | alu(5'd0), 1'b0);
      else            add_step(GRC | ROUT | ZLOWIN | alu(op), 1'b0);
      add_step(ZLOWOUT | GRA | RIN, 1'b0);
    end else if (op == 5'd10 || op == 5'd11) begin
      add_step(GRB | BAOUT | YIN, 1'b0);
      add_step(COUT | ZLOWIN | alu(5'd0), 1'b0);
      add_step(ZLOWOUT | MARIN, 1'b0);
      if (op == 5'd10) begin
        add_step(READ | MDRIN, 1'b1);
        add_step(MDROUT | GRA | RIN, 1'b0);
      end else begin
        add_step(GRA | ROUT | MDRIN, 1'b0);
        add_step(WRITE, 1'b1);
      end
    end else if (op == 5'd15 || op == 5'd16) begin
      add_step(GRA | ROUT | YIN, 1'b0);
      add_step(GRB | ROUT | ZLOWIN | ZHIGHIN | alu(op), 1'b0);
      add_step(ZLOWOUT | LOIN, 1'b0);
      add_step(ZHIGHOUT | HIIN, 1'b0);
    end else if (!op_legal(op)) begin
      add_step(ILLEGAL, 1'b0);
    end
  endtask

  // Stall counts < 0 pick a random number of MemReady-low cycles.
  task automatic run_instr(input logic [4:0] op, input int t1_stall, input int mem_stall,
                           input string tag);
    int k = 0;
    int cyc = 0;
    int left = 0;
    bit in_wait = 1'b0;
    build_steps(op);
    @(posedge Clock);
    #1 IR = {op, 27'($urandom)};
    while (k < steps.size()) begin
      @(negedge Clock);
      cyc++;
      if (cyc > 200) begin
        total++;
        bad++;
        $error("FAIL %s_timeout observed=%0d cycles expected<=200", tag, cyc);
        return;
      end
      check($sformatf("%s_step%0d", tag, k), obs, steps[k].ctl);
      if (steps[k].wait_mem) begin
        if (!in_wait) begin
          in_wait = 1'b1;
          left = (k == 1) ? t1_stall : mem_stall;
          if (left < 0) left = $urandom_range(0, 3);
        end
        if (left > 0) begin
          MemReady = 1'b0;
          left--;
        end else begin
          MemReady = 1'b1;
          in_wait = 1'b0;
          k++;
        end
      end else begin
        MemReady = 1'($urandom);
        k++;
      end
    end
  endtask

  initial begin
    logic [4:0] op;
    Clear = 1'b0;
    MemReady = 1'b0;
    IR = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("reset", obs, 30'd0);
    end
    Clear = 1'b1;

    IR = 32'h2A1B8000;
    run_instr(5'b00101, 0, 0, "rtype_and");
    run_instr(5'b01001, 1, 0, "addi");
    run_instr(5'b01010, 0, 2, "ld_wait2");
    run_instr(5'b01011, 0, 3, "st_wait3");
    run_instr(5'b01111, 0, 0, "mul");
    run_instr(5'b10000, 2, 0, "div");
    run_instr(5'b10101, 0, 0, "nop");
    run_instr(5'b11111, 0, 0, "illegal");
    run_instr(5'b01000, 0, 0, "rtype_max");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 5'($urandom_range(0, 31)); while (op_legal(op));
      end else begin
        do op = 5'($urandom_range(0, 31)); while (!op_legal(op) || op == 5'd27);
      end
      run_instr(op, -1, -1, $sformatf("rand%0d_op%0d", n, op));
    end

    // Clear during a fetch memory wait must drop everything at once.
    @(posedge Clock);
    #1 IR = {5'b01010, 27'd0};
    @(negedge Clock);
    check("clr_t0", obs, PCOUT | MARIN | INCPC | PCIN | RUN);
    MemReady = 1'b0;
    @(negedge Clock);
    check("clr_t1", obs, READ | MDRIN | RUN);
    @(negedge Clock);
    check("clr_t1_wait", obs, READ | MDRIN | RUN);
    Clear = 1'b0;
    #1 check("clr_async", obs, 30'd0);
    @(negedge Clock);
    check("clr_hold", obs, 30'd0);
    Clear = 1'b1;
    run_instr(5'b00011, -1, -1, "after_clr");

    run_instr(5'b11011, 0, 0, "halt");
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      MemReady = 1'($urandom);
      check($sformatf("halted%0d", i), obs, 30'd0);
    end
    Clear = 1'b0;
    @(negedge Clock);
    check("halt_clear", obs, 30'd0);
    Clear = 1'b1;
    run_instr(5'b01111, -1, -1, "after_halt");
    run_instr(5'b01010, -1, -1, "ld_after_halt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
